// File: rtl/truth_table_sweeper.sv
// Exhaustive clocked sweep comparing a canonical and a simplified Boolean form.
// Define SWEEPER_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            s1_in,
  input  logic            s2_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mism_cnt,
  output logic [N_IN-1:0] first_bad,
  output logic            first_bad_vld
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CMP,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t          state_q;
  logic [N_IN-1:0] vec_q;
  logic [N_IN-1:0] fb_q;
  logic            fbv_q;
  logic [N_IN:0]   mism_q;
  logic [3:0]      settle_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic            mis_d;
  logic [N_IN:0]   mism_d;
  logic            last_d;
  logic            stop_d;

  assign mis_d  = s1_in ^ s2_in;
  assign mism_d = mism_q + {{N_IN{1'b0}}, mis_d};
  assign last_d = &vec_q;

`ifdef SWEEPER_STOP_ON_FAIL_EN
  assign stop_d = mis_d;
`else
  assign stop_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      fb_q     <= '0;
      fbv_q    <= 1'b0;
      mism_q   <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= APPLY;
            vec_q    <= '0;
            fb_q     <= '0;
            fbv_q    <= 1'b0;
            mism_q   <= '0;
            settle_q <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        APPLY: begin
          if (abort) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
          end else if (settle_q == SETTLE_LAST) begin
            state_q <= CMP;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        CMP: begin
          // abort discards this cycle's comparison entirely
          if (abort) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
          end else begin
            if (mis_d) begin
              mism_q <= mism_d;
              if (!fbv_q) begin
                fb_q  <= vec_q;
                fbv_q <= 1'b1;
              end
            end
            if (last_d || stop_d) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mism_d == '0);
            end else begin
              state_q  <= APPLY;
              vec_q    <= vec_q + 1'b1;
              settle_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign mism_cnt      = mism_q;
  assign first_bad     = fb_q;
  assign first_bad_vld = fbv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: directed and random truth-table pairs
// against a set-based model, for SETTLE=1 and SETTLE=3 instances.
module tb_truth_table_sweeper;

`ifdef SWEEPER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  localparam logic [15:0] CANON  = 16'h5F00;
  localparam logic [15:0] FAULTY = 16'h5500;

  logic clk;
  logic rst_n;
  logic start_r [2];
  logic abort_r [2];
  logic [3:0] vec_w [2];
  logic s1_w [2];
  logic s2_w [2];
  logic busy_w [2];
  logic done_w [2];
  logic pass_w [2];
  logic [4:0] mism_w [2];
  logic [3:0] fb_w [2];
  logic fbv_w [2];

  logic [15:0] tt1;
  logic [15:0] tt2;

  int total = 0;
  int bad = 0;

  assign s1_w[0] = tt1[vec_w[0]];
  assign s2_w[0] = tt2[vec_w[0]];
  assign s1_w[1] = tt1[vec_w[1]];
  assign s2_w[1] = tt2[vec_w[1]];

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start(start_r[0]), .abort(abort_r[0]),
    .vec_out(vec_w[0]),
    .s1_in(s1_w[0]), .s2_in(s2_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .mism_cnt(mism_w[0]), .first_bad(fb_w[0]),
    .first_bad_vld(fbv_w[0])
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .start(start_r[1]), .abort(abort_r[1]),
    .vec_out(vec_w[1]),
    .s1_in(s1_w[1]), .s2_in(s2_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .mism_cnt(mism_w[1]), .first_bad(fb_w[1]),
    .first_bad_vld(fbv_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_vec", 32'(vec_w[d]), 0);
    chk("rst_busy", 32'(busy_w[d]), 0);
    chk("rst_done", 32'(done_w[d]), 0);
    chk("rst_pass", 32'(pass_w[d]), 0);
    chk("rst_mism", 32'(mism_w[d]), 0);
    chk("rst_fb", 32'(fb_w[d]), 0);
    chk("rst_fbv", 32'(fbv_w[d]), 0);
  endtask

  // Full sweep with model: mismatch set = t1^t2, result from set
  task automatic sweep(input int d, input int s, input logic [15:0] t1,
                       input logic [15:0] t2, input int rp, input bit sa);
    logic [15:0] diff;
    int ecnt, first, lat, evec, cyc;
    tt1 = t1;
    tt2 = t2;
    diff = t1 ^ t2;
    ecnt = $countones(diff);
    first = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) first = i;
    if (STOP && ecnt > 0) begin
      lat = (first + 1) * (s + 1);
      ecnt = 1;
      evec = first;
    end else begin
      lat = 16 * (s + 1);
      evec = 15;
    end
    @(negedge clk);
    start_r[d] = 1'b1;
    abort_r[d] = sa;
    @(negedge clk);
    start_r[d] = 1'b0;
    abort_r[d] = 1'b0;
    cyc = 0;
    chk("clr_mism", 32'(mism_w[d]), 0);
    chk("clr_fbv", 32'(fbv_w[d]), 0);
    chk("clr_done", 32'(done_w[d]), 0);
    chk("clr_pass", 32'(pass_w[d]), 0);
    while (!done_w[d] && cyc < 300) begin
      chk("busy", 32'(busy_w[d]), 1);
      chk("vec", 32'(vec_w[d]), 32'(cyc / (s + 1)));
      start_r[d] = (cyc == rp);
      @(negedge clk);
      cyc++;
    end
    start_r[d] = 1'b0;
    chk("latency", 32'(cyc), 32'(lat));
    chk("done", 32'(done_w[d]), 1);
    chk("busy_end", 32'(busy_w[d]), 0);
    chk("pass", 32'(pass_w[d]), 32'(ecnt == 0));
    chk("mism", 32'(mism_w[d]), 32'(ecnt));
    chk("fbv", 32'(fbv_w[d]), 32'(ecnt > 0));
    chk("fb", 32'(fb_w[d]), (ecnt > 0) ? 32'(first) : 0);
    chk("vec_end", 32'(vec_w[d]), 32'(evec));
  endtask

  task automatic abrt(input int d, input int s, input logic [15:0] t1,
                      input logic [15:0] t2, input int ab);
    logic [15:0] diff;
    int ec, first;
    tt1 = t1;
    tt2 = t2;
    diff = t1 ^ t2;
    ec = 0;
    first = -1;
    for (int v = 0; v < 16; v++) begin
      if ((v + 1) * (s + 1) <= ab && diff[v]) begin
        ec++;
        if (first < 0) first = v;
      end
    end
    if (STOP && ec > 1) ec = 1;
    @(negedge clk);
    start_r[d] = 1'b1;
    @(negedge clk);
    start_r[d] = 1'b0;
    for (int c = 0; c < ab; c++) @(negedge clk);
    chk("ab_busy_pre", 32'(busy_w[d]), 1);
    abort_r[d] = 1'b1;
    @(negedge clk);
    abort_r[d] = 1'b0;
    chk("ab_vec", 32'(vec_w[d]), 0);
    chk("ab_busy", 32'(busy_w[d]), 0);
    chk("ab_done", 32'(done_w[d]), 0);
    chk("ab_mism", 32'(mism_w[d]), 32'(ec));
    chk("ab_fbv", 32'(fbv_w[d]), 32'(ec > 0));
    repeat (3) @(negedge clk);
    chk("ab_idle", 32'(busy_w[d] | done_w[d]), 0);
  endtask

  initial begin
    logic [15:0] r1;
    logic [15:0] rm;
    int dd;
    rst_n = 1'b0;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    abort_r[0] = 1'b0;
    abort_r[1] = 1'b0;
    tt1 = CANON;
    tt2 = CANON;
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;

    sweep(0, 1, CANON, CANON, -1, 1'b0);
    sweep(0, 1, CANON, FAULTY, 10, 1'b0);
    sweep(0, 1, CANON, FAULTY, -1, 1'b1);
    sweep(1, 3, CANON, CANON, -1, 1'b0);
    sweep(1, 3, CANON, FAULTY, -1, 1'b0);

    abrt(0, 1, CANON, CANON ^ 16'h0040, 12);
    abrt(0, 1, CANON, CANON ^ 16'h0040, 13);
    abrt(1, 3, CANON, CANON ^ 16'h0005, 14);

    for (int i = 0; i < 6; i++) begin
      r1 = 16'($urandom);
      rm = 16'($urandom & $urandom & $urandom);
      if (i == 0) rm = 16'h0;
      dd = i % 2;
      sweep(dd, (dd == 1) ? 3 : 1, r1, r1 ^ rm, -1, 1'b0);
    end

    // reset mid-sweep, then hold reset with start asserted
    tt1 = CANON;
    tt2 = CANON ^ 16'h0003;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    start_r[0] = 1'b1;
    @(negedge clk);
    chk_reset(0);
    repeat (3) @(negedge clk);
    chk_reset(0);
    start_r[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset(0);

    sweep(0, 1, CANON, CANON, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
